// File: rtl/key_debounce.sv
// Push-button conditioner: per-key 2-flop synchroniser plus debounce FSM producing
// a clean active-low level, one-cycle press/release pulses and a press-toggled bit.
module key_debounce #(
    parameter int unsigned     NKEYS         = 4,
    parameter int unsigned     STABLE_CYCLES = 1000000,
    parameter int unsigned     CNT_W         = 20,
    parameter logic [NKEYS-1:0] TOGGLE_INIT  = NKEYS'(4'b0010)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [NKEYS-1:0] key_n,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] press_pulse,
    output logic [NKEYS-1:0] release_pulse,
    output logic [NKEYS-1:0] toggle
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [NKEYS-1:0] r_sync1;
    logic [NKEYS-1:0] r_sync2;
    state_t           r_state [NKEYS];
    logic [CNT_W-1:0] r_cnt   [NKEYS];

    // Raw pins are asynchronous; idle (released) level is 1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // A change commits only after STABLE_CYCLES consecutive samples at the new level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_level     <= '1;
            press_pulse   <= '0;
            release_pulse <= '0;
            toggle        <= TOGGLE_INIT;
            for (int i = 0; i < int'(NKEYS); i++) begin
                r_state[i] <= RELEASED;
                r_cnt[i]   <= '0;
            end
        end else begin
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < int'(NKEYS); i++) begin
                case (r_state[i])
                    RELEASED: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= PRESS_CHK;
                            r_cnt[i]   <= CNT_W'(1);
                        end else begin
                            r_cnt[i]   <= '0;
                        end
                    end
                    PRESS_CHK: begin
                        if (r_sync2[i]) begin
                            r_state[i] <= RELEASED;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == LAST_CNT) begin
                            r_state[i]     <= PRESSED;
                            r_cnt[i]       <= '0;
                            key_level[i]   <= 1'b0;
                            press_pulse[i] <= 1'b1;
                            toggle[i]      <= ~toggle[i];
                        end else begin
                            r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (r_sync2[i]) begin
                            r_state[i] <= RELEASE_CHK;
                            r_cnt[i]   <= CNT_W'(1);
                        end else begin
                            r_cnt[i]   <= '0;
                        end
                    end
                    RELEASE_CHK: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= PRESSED;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == LAST_CNT) begin
                            r_state[i]       <= RELEASED;
                            r_cnt[i]         <= '0;
                            key_level[i]     <= 1'b1;
                            release_pulse[i] <= 1'b1;
                        end else begin
                            r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state[i] <= RELEASED;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomised bench for key_debounce against a run-length reference model of
// the debounce rules, plus directed latency, bounce and reset scenarios.
module tb_key_debounce;

    localparam int unsigned NK    = 4;
    localparam int unsigned SC    = 4;
    localparam int unsigned CW    = 3;
    localparam logic [3:0]  TINIT = 4'b0010;

    logic          clock = 1'b0;
    logic          resetn;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] toggle;

    key_debounce #(
        .NKEYS         (NK),
        .STABLE_CYCLES (SC),
        .CNT_W         (CW),
        .TOGGLE_INIT   (TINIT)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .toggle        (toggle)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: raw samples reach the debouncer two edges late; a key commits
    // when SC consecutive delayed samples differ from its committed level.
    logic [NK-1:0] m_level, m_press, m_rel, m_tog;
    logic [NK-1:0] m_hist[$];
    int            m_run[NK];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = '1;
        m_press = '0;
        m_rel   = '0;
        m_tog   = TINIT;
        m_hist.delete();
        m_hist.push_back('1);
        m_hist.push_back('1);
        for (int i = 0; i < int'(NK); i++) m_run[i] = 0;
    endtask

    task automatic model_edge(input logic [NK-1:0] kn);
        logic [NK-1:0] seen;
        seen = m_hist.pop_front();
        m_hist.push_back(kn);
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < int'(NK); i++) begin
            if (seen[i] != m_level[i]) m_run[i]++;
            else                       m_run[i] = 0;
            if (m_run[i] == int'(SC)) begin
                m_run[i]   = 0;
                m_level[i] = seen[i];
                if (seen[i] == 1'b0) begin
                    m_press[i] = 1'b1;
                    m_tog[i]   = ~m_tog[i];
                end else begin
                    m_rel[i]   = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"},   32'(key_level),     32'(m_level));
        check({tag, ".press"},   32'(press_pulse),   32'(m_press));
        check({tag, ".release"}, 32'(release_pulse), 32'(m_rel));
        check({tag, ".toggle"},  32'(toggle),        32'(m_tog));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".level"},   32'(key_level),     32'(4'b1111));
        check({tag, ".press"},   32'(press_pulse),   32'(4'b0000));
        check({tag, ".release"}, 32'(release_pulse), 32'(4'b0000));
        check({tag, ".toggle"},  32'(toggle),        32'(TINIT));
    endtask

    // Drive one input value for one clock edge, then compare away from the edge.
    task automatic step(input logic [NK-1:0] kn, input string tag);
        key_n = kn;
        @(posedge clock);
        model_edge(kn);
        #1;
        check_all(tag);
    endtask

    int            pulses;
    logic [NK-1:0] rk;

    initial begin
        resetn = 1'b0;
        key_n  = '1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("reset");
        #2 resetn = 1'b1;
        model_reset();

        // Idle stability.
        for (int e = 0; e < 20; e++) step(4'b1111, "idle");

        // Hold key 0: commit on edge 6, single pulse, no auto-repeat.
        pulses = 0;
        for (int e = 1; e <= 56; e++) begin
            step(4'b1110, "hold0");
            check("hold0.lvl0", 32'(key_level[0]), (e >= 6) ? 32'd0 : 32'd1);
            if (press_pulse[0]) pulses++;
        end
        check("hold0.pulses", 32'(pulses), 32'd1);
        check("hold0.toggle", 32'(toggle), 32'(4'b0011));

        // Release key 0: commit on edge 6, toggle untouched.
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            step(4'b1111, "rel0");
            check("rel0.rpulse", 32'(release_pulse), (e == 6) ? 32'(4'b0001) : 32'd0);
            if (release_pulse[0]) pulses++;
        end
        check("rel0.pulses", 32'(pulses), 32'd1);
        check("rel0.toggle", 32'(toggle), 32'(4'b0011));

        // Bounce on key 1: low 3, high 1, low 3, then high.
        for (int e = 0; e < 20; e++) begin
            step((e < 3 || (e >= 4 && e < 7)) ? 4'b1101 : 4'b1111, "bounce1");
            check("bounce1.press", 32'(press_pulse), 32'd0);
            check("bounce1.lvl", 32'(key_level), 32'(4'b1111));
        end
        check("bounce1.toggle", 32'(toggle), 32'(4'b0011));

        // Keys 2 and 3 pressed together.
        for (int e = 1; e <= 10; e++) begin
            step(4'b0011, "dual");
            check("dual.press", 32'(press_pulse), (e == 6) ? 32'(4'b1100) : 32'd0);
        end
        check("dual.toggle", 32'(toggle), 32'(4'b1111));
        for (int e = 0; e < 10; e++) step(4'b1111, "dualrel");

        // Random bouncing: each key flips with probability ~1/6 per cycle.
        rk = '1;
        for (int e = 0; e < 600; e++) begin
            for (int i = 0; i < int'(NK); i++)
                if ($urandom_range(5, 0) == 0) rk[i] = ~rk[i];
            step(rk, "rand");
        end
        for (int e = 0; e < 12; e++) step(4'b1111, "settle");

        // Reset mid-qualification, key still held afterwards.
        for (int e = 1; e <= 4; e++) step(4'b1110, "prerst");
        resetn = 1'b0;
        #2;
        check_reset_vals("asyncrst");
        model_reset();
        #2 resetn = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 20; e++) begin
            step(4'b1110, "postrst");
            check("postrst.press", 32'(press_pulse), (e == 6) ? 32'(4'b0001) : 32'd0);
            if (press_pulse[0]) pulses++;
        end
        check("postrst.pulses", 32'(pulses), 32'd1);
        check("postrst.toggle", 32'(toggle), 32'(4'b0011));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
